// File: rtl/cache_pkg.sv
// Shared types for the L1 -> L2 request path.
package cache_pkg;

    localparam int LINE_ADDR_W = 26;

    localparam logic SRC_IC = 1'b0;
    localparam logic SRC_DC = 1'b1;

    typedef struct packed {
        logic [LINE_ADDR_W-1:0] addr;
        logic                   write;
        logic                   src;
    } l2_req_t;

endpackage

// File: rtl/req_fifo.sv
// Circular buffer of L2 requests with a CAM port that reports whether a
// read to the probed line is already held in the queue.
module req_fifo
    import cache_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int OCC_W = PTR_W + 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push_i,
    input  l2_req_t                push_data_i,
    input  logic                   pop_i,
    output l2_req_t                head_o,
    output logic [OCC_W-1:0]       count_o,
    input  logic [LINE_ADDR_W-1:0] cam_addr_i,
    output logic                   cam_hit_o
);

    l2_req_t            mem_q [DEPTH];
    logic [DEPTH-1:0]   vld_q;
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [OCC_W-1:0]   count_q;
    logic               pop_do;

    assign pop_do = pop_i & (count_q != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            vld_q    <= '0;
        end else begin
            // Pop clears first so a push to the same slot (only possible on wrap) wins.
            if (pop_do) begin
                vld_q[rd_ptr_q] <= 1'b0;
                rd_ptr_q        <= rd_ptr_q + 1'b1;
            end
            if (push_i) begin
                vld_q[wr_ptr_q] <= 1'b1;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            case ({push_i, pop_do})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign head_o  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign count_o = count_q;

    // Only held reads are merge targets; writebacks never absorb a request.
    always_comb begin
        cam_hit_o = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld_q[i] && !mem_q[i].write && mem_q[i].addr == cam_addr_i)
                cam_hit_o = 1'b1;
        end
    end

endmodule

// File: rtl/l2_miss_queue.sv
// L1 miss/writeback queue towards L2: round-robin IC/DC arbitration,
// read merging against held lines, in-order issue and saturating statistics.
module l2_miss_queue
    import cache_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = LINE_ADDR_W,
    parameter int CNT_W  = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    ic_req_valid,
    input  logic [ADDR_W-1:0]       ic_req_addr,
    output logic                    ic_req_ready,
    input  logic                    dc_req_valid,
    input  logic [ADDR_W-1:0]       dc_req_addr,
    input  logic                    dc_req_write,
    output logic                    dc_req_ready,
    output logic                    l2_req_valid,
    output logic [ADDR_W-1:0]       l2_req_addr,
    output logic                    l2_req_write,
    output logic                    l2_req_src,
    input  logic                    l2_req_ready,
    output logic [$clog2(DEPTH):0]  occupancy,
    output logic [CNT_W-1:0]        issued_count,
    output logic [CNT_W-1:0]        merged_count
);

    localparam int OCC_W = $clog2(DEPTH) + 1;

    logic             rr_q, rr_d;
    logic [CNT_W-1:0] issued_q, issued_d;
    logic [CNT_W-1:0] merged_q, merged_d;

    l2_req_t req, head;
    logic    contested, any_req, grant_ic, grant_dc;
    logic    cam_hit, merge_hit, has_room, accept, push, pop;

    always_comb begin
        contested = ic_req_valid & dc_req_valid;
        any_req   = ic_req_valid | dc_req_valid;
        grant_dc  = dc_req_valid & (~ic_req_valid | rr_q);
        grant_ic  = ic_req_valid & ~grant_dc;
        req.addr  = grant_dc ? dc_req_addr : ic_req_addr;
        req.write = grant_dc & dc_req_write;
        req.src   = grant_dc ? SRC_DC : SRC_IC;
        merge_hit = any_req & ~req.write & cam_hit;
        // Room is judged on registered occupancy; a pop this cycle does not help.
        has_room  = occupancy < OCC_W'(DEPTH);
        accept    = any_req & (merge_hit | has_room);
        push      = accept & ~merge_hit;
        pop       = l2_req_valid & l2_req_ready;
    end

    assign ic_req_ready = grant_ic & (merge_hit | has_room);
    assign dc_req_ready = grant_dc & (merge_hit | has_room);

    req_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (push),
        .push_data_i (req),
        .pop_i       (pop),
        .head_o      (head),
        .count_o     (occupancy),
        .cam_addr_i  (req.addr),
        .cam_hit_o   (cam_hit)
    );

    assign l2_req_valid = (occupancy != '0);
    assign l2_req_addr  = head.addr;
    assign l2_req_write = head.write;
    assign l2_req_src   = head.src;

    always_comb begin
        rr_d     = contested ? ~rr_q : rr_q;
        issued_d = (pop && issued_q != '1) ? issued_q + CNT_W'(1) : issued_q;
        merged_d = (accept && merge_hit && merged_q != '1) ? merged_q + CNT_W'(1) : merged_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_q     <= 1'b0;
            issued_q <= '0;
            merged_q <= '0;
        end else begin
            rr_q     <= rr_d;
            issued_q <= issued_d;
            merged_q <= merged_d;
        end
    end

    assign issued_count = issued_q;
    assign merged_count = merged_q;

endmodule
